// File: rtl/decoder_seq.sv
// Registered binary decoder with one-hot, thermometer, timed one-hot sweep and sticky modes.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a code; d holds the last decoded vector
// S_SWEEP | walking a single set bit from position 0 up to the target
module decoder_seq #(
   parameter int K = 6
) (
`ifdef USE_POWER_PINS
   inout  wire              vccd1,
   inout  wire              vssd1,
`endif
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [K-1:0]     io_in,
   input  logic [1:0]       mode,
   input  logic             clear,
   output logic [(1<<K)-1:0] io_out,
   output logic             out_valid,
   output logic             busy
);

   localparam int N = 1 << K;

   localparam logic [1:0] M_ONEHOT = 2'b00;
   localparam logic [1:0] M_THERMO = 2'b01;
   localparam logic [1:0] M_SWEEP  = 2'b10;
   localparam logic [1:0] M_STICKY = 2'b11;

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t       state;
   logic [N-1:0] d;
   logic [K-1:0] pos;
   logic [K-1:0] tgt;
   logic [1:0]   mode_q;
   logic         done;

   logic         accept;
   logic         sticky_clr;
   logic [N-1:0] bit_v;
   logic [N-1:0] thermo_v;

   assign in_ready   = enable & (state == S_IDLE) & ~wb_rst_i;
   assign accept     = in_valid & in_ready;
   assign busy       = (state == S_SWEEP);
   assign io_out     = enable ? d : '0;
   assign out_valid  = done & ~wb_rst_i;
   assign sticky_clr = clear & (mode_q == M_STICKY);

   // (1 << (v+1)) - 1 wraps to all ones when v = N-1
   assign bit_v    = N'(1) << io_in;
   assign thermo_v = (bit_v << 1) - N'(1);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= S_IDLE;
         d      <= '0;
         pos    <= '0;
         tgt    <= '0;
         mode_q <= M_ONEHOT;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mode_q <= mode;
                  case (mode)
                     M_ONEHOT: begin
                        d    <= bit_v;
                        done <= 1'b1;
                     end
                     M_THERMO: begin
                        d    <= thermo_v;
                        done <= 1'b1;
                     end
                     M_STICKY: begin
                        d    <= (sticky_clr ? '0 : d) | bit_v;
                        done <= 1'b1;
                     end
                     default: begin
                        d     <= N'(1);
                        pos   <= '0;
                        tgt   <= io_in;
                        state <= S_SWEEP;
                     end
                  endcase
               end else if (sticky_clr) begin
                  d <= '0;
               end
            end
            S_SWEEP: begin
               // enable low freezes pos and d so the sweep resumes where it paused
               if (enable) begin
                  if (pos == tgt) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end else begin
                     pos <= pos + K'(1);
                     d   <= d << 1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: directed scenarios plus randomized traffic against a queue-based model.
module tb_decoder_seq;

   localparam int K = 6;
   localparam int N = 64;

   logic         clk = 1'b0;
   logic         rst, en, vld, clr;
   logic [1:0]   md;
   logic [K-1:0] code;
   logic         rdy, ov, bsy;
   logic [N-1:0] io_out_w;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [N-1:0] d;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   logic [N-1:0] frames[$];
   logic [N-1:0] m_d = '0;
   logic [1:0]   m_mode = 2'd0;

   decoder_seq #(.K(K)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .enable   (en),
      .in_valid (vld),
      .in_ready (rdy),
      .io_in    (code),
      .mode     (md),
      .clear    (clr),
      .io_out   (io_out_w),
      .out_valid(ov),
      .busy     (bsy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] bitv(input int i);
      logic [N-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   // Drive one cycle of inputs, advance the model across the next edge, then compare.
   task automatic step(input logic e, input logic v, input logic [1:0] m, input int c,
                       input logic cl, input logic r);
      logic busy_m;
      exp_t x;
      en = e; vld = v; md = m; code = K'(c); clr = cl; rst = r;
      #1;
      busy_m = (frames.size() != 0);
      chk("in_ready", N'(rdy), N'(e & ~busy_m & ~r));
      chk("io_out_pre", io_out_w, e ? m_d : '0);
      if (r) begin
         m_d    = '0;
         m_mode = 2'd0;
         frames.delete();
      end else if (e && v && !busy_m) begin
         case (m)
            2'd0: m_d = bitv(c);
            2'd1: begin
               m_d = '0;
               for (int i = 0; i <= c; i++) m_d[i] = 1'b1;
            end
            2'd3: begin
               if (cl && m_mode == 2'd3) m_d = '0;
               m_d[c] = 1'b1;
            end
            default: begin
               for (int i = 0; i <= c; i++) frames.push_back(bitv(i));
               m_d = frames[0];
            end
         endcase
         if (m != 2'd2) begin
            x.d = m_d; x.cyc = cyc + 1;
            sb.push_back(x);
         end
         m_mode = m;
      end else if (busy_m && e) begin
         void'(frames.pop_front());
         if (frames.size() == 0) begin
            x.d = m_d; x.cyc = cyc + 1;
            sb.push_back(x);
         end else begin
            m_d = frames[0];
         end
      end else if (!busy_m && cl && m_mode == 2'd3) begin
         m_d = '0;
      end
      @(posedge clk);
      #1;
      chk("io_out", io_out_w, e ? m_d : '0);
      chk("busy", N'(bsy), N'(frames.size() != 0));
   endtask

   // Monitor: every out_valid pulse must match the oldest expected completion.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (rst === 1'b1) begin
            chk("out_valid_in_reset", N'(ov), N'(0));
            while (sb.size() != 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
         end else if (ov === 1'b1) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_out_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
               x = sb.pop_front();
               chk("ov_data", io_out_w, en ? x.d : '0);
               chk("ov_cycle", N'(cyc), N'(x.cyc));
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_out_valid: got 0 expected 1 at cycle %0d", cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      int nb;
      en = 0; vld = 0; md = 0; code = 0; clr = 0; rst = 1;

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_io_out", io_out_w, '0);
      chk("rst_busy", N'(bsy), N'(0));
      chk("rst_out_valid", N'(ov), N'(0));
      step(1, 0, 0, 0, 0, 0);

      step(1, 1, 2'd0, 37, 0, 0);
      chk("onehot37", io_out_w, bitv(37));
      chk("onehot37_valid", N'(ov), N'(1));
      step(1, 1, 2'd0, 0, 0, 0);
      chk("onehot0", io_out_w, 64'h1);
      step(1, 0, 2'd0, 0, 0, 0);
      chk("onehot_valid_low", N'(ov), N'(0));

      step(1, 1, 2'd1, 63, 0, 0);
      chk("thermo63", io_out_w, {N{1'b1}});
      step(1, 1, 2'd1, 5, 0, 0);
      chk("thermo5", io_out_w, 64'h3F);

      step(1, 1, 2'd2, 3, 0, 0);
      nb = 0;
      for (int g = 0; g < 40 && bsy === 1'b1; g++) begin
         if (nb <= 3) chk("sweep3_trace", io_out_w, bitv(nb));
         nb++;
         step(1, 1, 2'd0, 9, 0, 0);
      end
      chk("sweep3_busy_len", N'(nb), N'(4));
      chk("sweep3_final", io_out_w, bitv(3));
      chk("sweep3_valid", N'(ov), N'(1));
      step(1, 1, 2'd0, 9, 0, 0);
      chk("accept_after_sweep", io_out_w, bitv(9));

      step(1, 1, 2'd2, 10, 0, 0);
      nb = 1;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 2'd0, 0, 0, 0);
         if (bsy) nb++;
      end
      chk("sweep10_pos4", io_out_w, bitv(4));
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 2'd0, 1, 0, 0);
         chk("sweep10_gap", io_out_w, '0);
         if (bsy) nb++;
      end
      step(1, 0, 2'd0, 0, 0, 0);
      chk("sweep10_resume", io_out_w, bitv(5));
      if (bsy) nb++;
      for (int g = 0; g < 40 && bsy === 1'b1; g++) begin
         step(1, 0, 2'd0, 0, 0, 0);
         if (bsy) nb++;
      end
      chk("sweep10_busy_len", N'(nb), N'(14));

      step(1, 1, 2'd2, 19, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 2'd0, 0, 0, 0);
      chk("sweep19_pos6", io_out_w, bitv(6));
      step(1, 0, 2'd0, 0, 0, 1);
      chk("midsweep_rst_out", io_out_w, '0);
      chk("midsweep_rst_busy", N'(bsy), N'(0));
      step(1, 0, 2'd0, 0, 0, 0);
      step(1, 1, 2'd0, 12, 0, 0);
      chk("post_rst_onehot", io_out_w, bitv(12));

      step(1, 0, 2'd0, 0, 0, 1);
      step(1, 1, 2'd3, 2, 0, 0);
      step(1, 1, 2'd3, 7, 0, 0);
      step(1, 1, 2'd3, 63, 0, 0);
      chk("sticky_acc", io_out_w, bitv(63) | 64'h84);
      step(1, 1, 2'd3, 1, 1, 0);
      chk("sticky_clr_accept", io_out_w, 64'h2);
      step(1, 0, 2'd0, 0, 1, 0);
      chk("sticky_clr_only", io_out_w, '0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 60,
              2'($urandom_range(0, 3)),
              int'($urandom_range(0, N - 1)),
              $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 2);
      end

      for (int g = 0; g < 100 && frames.size() != 0; g++) step(1, 0, 2'd0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 0, 0);
      chk("drain_busy", N'(bsy), N'(0));
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised successor to the combinational binary-to-one-hot decoder in the decoder project. It accepts a K-bit code over a valid/ready handshake and drives a 2**K-bit output vector in one of four modes: one-hot, thermometer, timed one-hot sweep, or sticky accumulate. It sits between user I/O and downstream select or enable fabric that needs glitch-free, registered selects and multi-cycle sequencing.

## Interface
- K, default 6: input code width; output width is N = 2**K. Legal range 1..8.
- vccd1, vssd1: inout power pins, present only under USE_POWER_PINS.
- wb_clk_i  input  1  sole clock; all logic is on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- enable  input  1  global enable; gates acceptance and masks io_out.
- in_valid  input  1  the code on io_in and the mode are offered.
- in_ready  output  1  block can accept a code this cycle.
- io_in  input  K  binary code v, unsigned.
- mode  input  2  00 ONEHOT, 01 THERMO, 10 SWEEP, 11 STICKY; sampled only on accept.
- clear  input  1  clears the STICKY accumulator.
- io_out  output  N  registered decoded vector.
- out_valid  output  1  one-cycle pulse when a transaction's output is complete.
- busy  output  1  high while a SWEEP is in progress.

## Operation
- Accept = in_valid & in_ready. in_ready = enable & ~busy & ~wb_rst_i.
- Internal state: fsm {IDLE, SWEEP}, data register D[N-1:0], position counter pos[K-1:0], target tgt[K-1:0], latched mode.
- io_out = D when enable = 1, else all zeros. Masking applies to the output only; D is preserved.
- ONEHOT on accept: D <= bit v only.
- THERMO on accept: D <= bits [v:0] set and all others clear. v = N-1 gives all ones; v = 0 gives 0x1.
- STICKY on accept: D <= D | (1 << v). D holds across accepts until clear or reset.
- STICKY clear without accept: D <= 0.
- STICKY clear in the same cycle as an accept: D <= (1 << v). The clear is applied before the OR.
- clear has no effect in any mode other than STICKY (the latched mode).
- Changing mode on an accept replaces D according to the new mode. The only exception is STICKY, which ORs into the current D.
- SWEEP on accept:
  - Sets tgt <= v, pos <= 0, D <= 0x1, and fsm -> SWEEP.
  - In SWEEP with enable = 1: if pos == tgt, go to IDLE and pulse out_valid. Otherwise pos <= pos + 1 and D <= 1 << (pos + 1).
  - In SWEEP with enable = 0: pos and D are frozen, so the sweep pauses and resumes when enable returns.
- busy = (fsm == SWEEP).
- The counter never wraps: pos <= tgt <= N-1.
- mode, io_in and clear are ignored while busy, except that clear still has no effect.
- Reset (any cycle, including mid-sweep) sets D = 0, pos = 0, tgt = 0, fsm = IDLE, latched mode = ONEHOT.

## Timing
- Reset values: io_out = 0, out_valid = 0, busy = 0. in_ready = 0 while wb_rst_i is high. in_ready = enable on the cycle after reset deasserts.
- ONEHOT, THERMO and STICKY: accept at edge t updates io_out after edge t, giving a latency of 1. out_valid is high for the cycle after edge t.
- These three modes accept back-to-back every cycle, at a throughput of 1 per cycle.
- SWEEP with target v: io_out shows bit 0 after the accepting edge, then bit 1, ..., bit v, one per enabled cycle.
  - busy is high for v+1 cycles.
  - out_valid pulses for one cycle on the cycle after bit v's final cycle, when the FSM returns to IDLE.
  - io_out then holds bit v until the next accept.
  - The next accept is possible in the same cycle that busy falls.
- v = 0 sweep: busy is high for 1 cycle, and io_out = 0x1 throughout.
- enable low for m cycles mid-sweep extends busy by exactly m cycles.
- out_valid is never asserted while wb_rst_i is high.

## Test plan
- Reset, then ONEHOT accept with K=6 and io_in=37 → next cycle io_out = 1<<37 and out_valid = 1 for exactly one cycle; then io_in=0 back-to-back → io_out = 0x1.
- THERMO with io_in=63 → io_out = all ones (64 bits); io_in=5 → io_out = 0x3F.
- SWEEP with io_in=3 → io_out is 0x1, 0x2, 0x4, 0x8 on consecutive cycles; busy is high for 4 cycles; in_ready is low throughout; in_valid offered during the sweep is not accepted; out_valid pulses after 0x8.
- SWEEP with io_in=10 and enable dropped for 3 cycles at pos=4 → io_out = 0 during the gap, resumes at bit 4 then bit 5, and busy totals 14 cycles.
- STICKY accepts of 2, 7 and 63 → io_out = (1<<63)|0x84; then clear together with an accept of 1 → io_out = 0x2; then clear alone → io_out = 0.
- wb_rst_i asserted at pos=6 of a 20-step sweep → next cycle io_out = 0, busy = 0, and no out_valid pulse; after release a ONEHOT accept works normally.
